traffic_light_sequencer: RTL and testbench

Consumes the 32-bit command word driven by the HPS-writable output PIO bank and runs the two-way intersection light sequence (north-south / east-west) with per-phase durations taken from that word. A one-second tick prescaler times the phases, and a latched pedestrian request adds a walk interval. A status word is produced for readback through an input PIO.

---
 rtl/traffic_light_sequencer.sv | 123 ++++++++++++
 tb/tb_traffic_light_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: two-way intersection light sequencer with tick prescaler, flash mode and pedestrian walk
module traffic_light_sequencer #(
  parameter int TICK_DIV   = 50000000,
  parameter int WALK_TICKS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  input  logic        ped_btn,
  output logic [2:0]  ns_lamp,
  output logic [2:0]  ew_lamp,
  output logic        ped_walk,
  output logic [31:0] status
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED1  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALL_RED2  = 3'd6,
    FLASH     = 3'd7
  } state_t;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  state_t          state, state_nx;
  logic [PW-1:0]   presc, presc_nx;
  logic [7:0]      remaining, remaining_nx, phase_len;
  logic [7:0]      green_t, yellow_t, allred_t, walk_t;
  logic [31:0]     walk_sum;
  logic [2:0]      ped_sync;
  logic [2:0]      ns_nx, ew_nx;
  logic            ped_pending, ped_pending_nx;
  logic            flash_phase, flash_phase_nx;
  logic            walk_nx, tick, entry, allred_nx, serve, ped_rise, run, flash;
  logic            unused_cmd;
  assign run        = cmd_word[0];
  assign flash      = cmd_word[1];
  assign unused_cmd = ^{cmd_word[31:20], cmd_word[3:2]};
  assign tick       = presc == PMAX;
  assign ped_rise   = ped_sync[1] & ~ped_sync[2];
  // zero-length fields run as a single tick
  assign green_t    = cmd_word[11:4] == 8'd0 ? 8'd1 : cmd_word[11:4];
  assign yellow_t   = {4'd0, cmd_word[15:12] == 4'd0 ? 4'd1 : cmd_word[15:12]};
  assign allred_t   = {4'd0, cmd_word[19:16] == 4'd0 ? 4'd1 : cmd_word[19:16]};
  assign walk_sum   = 32'(allred_t) + 32'(WALK_TICKS);
  assign walk_t     = walk_sum > 32'd255 ? 8'hff : walk_sum[7:0];
  // synchronize the button and keep one extra stage for rising-edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ped_sync <= 3'd0;
    else ped_sync <= {ped_sync[1:0], ped_btn};
  // next state: run=0 beats flash, flash beats the tick-driven sequence
  always_comb begin
    state_nx = state;
    if (!run) state_nx = IDLE;
    else if (flash) state_nx = FLASH;
    else if (state == IDLE || state == FLASH) state_nx = ALL_RED1;
    else if (tick && remaining == 8'd1)
      case (state)
        ALL_RED1:  state_nx = NS_GREEN;
        NS_GREEN:  state_nx = NS_YELLOW;
        NS_YELLOW: state_nx = ALL_RED2;
        ALL_RED2:  state_nx = EW_GREEN;
        EW_GREEN:  state_nx = EW_YELLOW;
        EW_YELLOW: state_nx = ALL_RED1;
        default:   state_nx = state;
      endcase
  end
  // phase timing, pedestrian bookkeeping and the lamp pattern of the upcoming state
  always_comb begin
    entry          = state_nx != state;
    allred_nx      = state_nx == ALL_RED1 || state_nx == ALL_RED2;
    serve          = entry & allred_nx & ped_pending;
    phase_len      = (state_nx == NS_GREEN  || state_nx == EW_GREEN)  ? green_t  :
                     (state_nx == NS_YELLOW || state_nx == EW_YELLOW) ? yellow_t :
                     allred_nx ? (ped_pending ? walk_t : allred_t) : 8'd0;
    remaining_nx   = entry ? phase_len :
                     (tick && remaining > 8'd1) ? remaining - 8'd1 : remaining;
    presc_nx       = (entry || tick) ? '0 : presc + 1'b1;
    ped_pending_nx = ped_rise | (ped_pending & ~serve);
    walk_nx        = allred_nx & (entry ? ped_pending : ped_walk);
    flash_phase_nx = state_nx == FLASH && (entry || (flash_phase ^ tick));
    ns_nx          = 3'b100;
    ew_nx          = 3'b100;
    case (state_nx)
      NS_GREEN:  ns_nx = 3'b001;
      NS_YELLOW: ns_nx = 3'b010;
      EW_GREEN:  ew_nx = 3'b001;
      EW_YELLOW: ew_nx = 3'b010;
      FLASH: begin
        ns_nx = {1'b0, flash_phase_nx, 1'b0};
        ew_nx = {1'b0, flash_phase_nx, 1'b0};
      end
      default: ;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // registered datapath and outputs, all updated together so status mirrors the lamps
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      presc       <= '0;
      remaining   <= 8'd0;
      ped_pending <= 1'b0;
      flash_phase <= 1'b0;
      ns_lamp     <= 3'b100;
      ew_lamp     <= 3'b100;
      ped_walk    <= 1'b0;
      status      <= 32'd0;
    end else begin
      presc       <= presc_nx;
      remaining   <= remaining_nx;
      ped_pending <= ped_pending_nx;
      flash_phase <= flash_phase_nx;
      ns_lamp     <= ns_nx;
      ew_lamp     <= ew_nx;
      ped_walk    <= walk_nx;
      status      <= {16'd0, remaining_nx, 3'd0, ped_pending_nx, walk_nx, state_nx};
    end
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb_traffic_light_sequencer: directed scenarios with an event scoreboard on lamp/state changes
module tb_traffic_light_sequencer;
  localparam int R = 3'b100, Y = 3'b010, G = 3'b001;
  logic        clk, reset_n, ped_btn, ped_walk;
  logic [31:0] cmd_word, status;
  logic [2:0]  ns_lamp, ew_lamp;
  int errors = 0, checks = 0;
  typedef struct {
    int code, ns, ew, walk, pend, rem, dur;
  } exp_t;
  exp_t q[$];
  traffic_light_sequencer #(.TICK_DIV(4), .WALK_TICKS(5)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_word(cmd_word), .ped_btn(ped_btn),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .ped_walk(ped_walk), .status(status)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // expected response of one observable change; -1 leaves rem/dur unchecked
  task automatic push(input int code, input int ns, input int ew, input int walk,
                      input int pend, input int rem, input int dur);
    exp_t e;
    e = '{code, ns, ew, walk, pend, rem, dur};
    q.push_back(e);
  endtask
  task automatic wait_code(input int code);
    int n = 0;
    while (int'(status[2:0]) != code && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait state", int'(status[2:0]), code);
  endtask
  // monitor: an output event is any change of state code, lamps, walk or pending
  logic [10:0] snap, prev = {3'd0, 3'b100, 3'b100, 1'b0, 1'b0};
  int cyc = 0, last = 0, evt = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    snap = {status[2:0], ns_lamp, ew_lamp, ped_walk, status[4]};
    if (snap != prev) begin
      evt++;
      if (q.size() == 0) begin
        chk($sformatf("unexpected event %0d", evt), int'(snap), -1);
      end else begin
        e = q.pop_front();
        chk($sformatf("ev%0d code", evt), int'(status[2:0]), e.code);
        chk($sformatf("ev%0d ns", evt), int'(ns_lamp), e.ns);
        chk($sformatf("ev%0d ew", evt), int'(ew_lamp), e.ew);
        chk($sformatf("ev%0d walk", evt), int'(ped_walk), e.walk);
        chk($sformatf("ev%0d status walk", evt), int'(status[3]), e.walk);
        chk($sformatf("ev%0d pending", evt), int'(status[4]), e.pend);
        if (e.rem >= 0) chk($sformatf("ev%0d remaining", evt), int'(status[15:8]), e.rem);
        if (e.dur >= 0) chk($sformatf("ev%0d duration", evt), cyc - last, e.dur);
      end
      prev = snap;
      last = cyc;
    end
  end
  initial begin
    reset_n  = 1;
    cmd_word = 0;
    ped_btn  = 0;
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("reset ns", int'(ns_lamp), R);
    chk("reset ew", int'(ew_lamp), R);
    chk("reset walk", int'(ped_walk), 0);
    chk("reset status", int'(status), 0);
    reset_n = 1;
    @(negedge clk);
    // normal sequence with a pedestrian request served in ALL_RED2
    push(3, R, R, 0, 0, 1, -1);
    push(1, G, R, 0, 0, 3, 4);
    push(1, G, R, 0, 1, 3, 3);
    push(2, Y, R, 0, 1, 2, 9);
    push(6, R, R, 1, 0, 6, 8);
    push(4, R, G, 0, 0, 3, 24);
    push(5, R, Y, 0, 0, 2, 12);
    push(3, R, R, 0, 0, 1, 8);
    push(1, G, R, 0, 0, 3, 4);
    cmd_word = 32'h0001_2031;
    wait_code(1);
    ped_btn = 1;
    repeat (2) @(negedge clk);
    ped_btn = 0;
    wait_code(6);
    wait_code(3);
    wait_code(1);
    // green field zeroed mid-phase: current green keeps 3 ticks, later greens run 1 tick
    push(2, Y, R, 0, 0, 2, 12);
    push(6, R, R, 0, 0, 1, 8);
    push(4, R, G, 0, 0, 1, 4);
    push(5, R, Y, 0, 0, 2, 4);
    push(3, R, R, 0, 0, 1, 8);
    push(1, G, R, 0, 0, 1, 4);
    repeat (2) @(negedge clk);
    cmd_word = 32'h0001_2001;
    wait_code(4);
    wait_code(3);
    wait_code(1);
    push(2, Y, R, 0, 0, 2, 4);
    push(6, R, R, 0, 0, 1, 8);
    push(4, R, G, 0, 0, 3, 4);
    cmd_word = 32'h0001_2031;
    wait_code(4);
    // flash requested mid EW_GREEN, then released
    push(7, Y, Y, 0, 0, -1, 4);
    push(7, 0, 0, 0, 0, -1, 4);
    push(7, Y, Y, 0, 0, -1, 4);
    push(3, R, R, 0, 0, 1, 3);
    push(1, G, R, 0, 0, 3, 4);
    push(2, Y, R, 0, 0, 2, 12);
    repeat (3) @(negedge clk);
    cmd_word = 32'h0001_2033;
    wait_code(7);
    repeat (10) @(negedge clk);
    cmd_word = 32'h0001_2031;
    wait_code(2);
    // run dropped mid NS_YELLOW
    push(0, R, R, 0, 0, -1, 3);
    repeat (2) @(negedge clk);
    cmd_word = 32'h0001_2030;
    wait_code(0);
    // restart, then asynchronous reset mid NS_GREEN
    push(3, R, R, 0, 0, 1, -1);
    push(1, G, R, 0, 0, 3, 4);
    push(0, R, R, 0, 0, -1, -1);
    cmd_word = 32'h0001_2031;
    wait_code(1);
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("async reset ns", int'(ns_lamp), R);
    chk("async reset ew", int'(ew_lamp), R);
    chk("async reset walk", int'(ped_walk), 0);
    chk("async reset status", int'(status), 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
